// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns each chip-select frame into one register-bus transaction.
// SCK/CSN/MOSI are oversampled in the clk domain; all SPI edges are detected on synchronised copies.
module spi_reg_bridge #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_sck,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              val,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  output logic              busy,
  output logic              frame_err,
  output logic              timeout_err
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    BUS_WR = 3'd3,
    BUS_RD = 3'd4,
    TURN   = 3'd5,
    RDATA  = 3'd6,
    DRAIN  = 3'd7
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sr, csn_sr, mosi_sr;
  logic sck_s, csn_s, mosi_s, sck_prev, csn_prev;
  logic sck_rise, sck_fall, csn_rise, csn_fall;

  logic [DATA_W-2:0] rx;
  logic [DATA_W-1:0] rx_next;
  logic [15:0]       cmd_word;
  logic [9:0]        cmd_addr;
  logic [DATA_W-1:0] tx;
  logic [CNT_W-1:0]  bitcnt;
  logic [TCNT_W-1:0] tcnt;
  logic loaded, abort, err_set;
  logic bus_state, bus_tmo, bus_done, count_edge;

  // Chip select synchronises to idle-high so miso_oe stays low through reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sr   <= '0;
      csn_sr   <= '1;
      mosi_sr  <= '0;
      sck_prev <= 1'b0;
      csn_prev <= 1'b1;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
      csn_sr   <= {csn_sr[SYNC_STAGES-2:0], spi_csn};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sck_prev <= sck_s;
      csn_prev <= csn_s;
    end
  end

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign csn_s    = csn_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign csn_rise = csn_s & ~csn_prev;
  assign csn_fall = ~csn_s & csn_prev;

  assign rx_next   = {rx, mosi_s};
  assign cmd_word  = rx_next[15:0];
  assign bus_state = (state == BUS_WR) || (state == BUS_RD);
  assign bus_tmo   = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign bus_done  = bus_state && (ready || bus_tmo);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      IDLE: if (csn_fall) state_next = CMD;
      CMD: begin
        if (csn_rise) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (sck_rise && bitcnt == CNT_W'(15)) begin
          if (cmd_word[14:10] != 5'd0) begin
            state_next = DRAIN;
            err_set    = 1'b1;
          end else begin
            state_next = cmd_word[15] ? WDATA : BUS_RD;
          end
        end
      end
      WDATA: begin
        if (csn_rise) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (sck_rise && bitcnt == CNT_W'(DATA_W - 1)) begin
          state_next = BUS_WR;
        end
      end
      // A frame abandoned during the bus phase still lets the transaction finish first.
      BUS_WR, BUS_RD: begin
        if (bus_done) begin
          if (abort || csn_rise) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end else begin
            state_next = (state == BUS_WR) ? DRAIN : TURN;
          end
        end
      end
      TURN: begin
        if (csn_rise) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (sck_rise && bitcnt == CNT_W'(7)) begin
          state_next = RDATA;
        end
      end
      RDATA: begin
        if (csn_rise) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else if (sck_fall && loaded && bitcnt == CNT_W'(DATA_W - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (csn_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    val         = bus_state;
    busy        = (state != IDLE);
    spi_miso_oe = ~csn_s;
    spi_miso    = ((state == RDATA) && loaded) ? tx[DATA_W-1] : 1'b0;
  end

  // Dummy edges arriving while BUS_RD waits on the bus still count toward the turnaround.
  assign count_edge = (((state == CMD) || (state == WDATA) || (state == BUS_RD) ||
                        (state == TURN)) && sck_rise) ||
                      ((state == RDATA) && sck_fall && loaded);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx          <= '0;
      bitcnt      <= '0;
      tcnt        <= '0;
      tx          <= '0;
      loaded      <= 1'b0;
      abort       <= 1'b0;
      cmd_addr    <= '0;
      addr        <= '0;
      write       <= 1'b0;
      wdata       <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_err <= err_set;
      if (bus_state && !ready && bus_tmo) timeout_err <= 1'b1;

      if (((state == CMD) || (state == WDATA)) && sck_rise) rx <= rx_next[DATA_W-2:0];

      if ((state_next != state) && (state != BUS_RD)) bitcnt <= '0;
      else if (count_edge)                             bitcnt <= bitcnt + 1'b1;

      if (bus_state) tcnt <= tcnt + 1'b1;
      else           tcnt <= '0;

      if ((state == CMD) && sck_rise && bitcnt == CNT_W'(15)) cmd_addr <= cmd_word[9:0];

      if ((state == WDATA) && (state_next == BUS_WR)) begin
        wdata <= rx_next;
        addr  <= ADDR_W'(cmd_addr);
        write <= 1'b1;
      end else if ((state == CMD) && (state_next == BUS_RD)) begin
        addr  <= ADDR_W'(cmd_word[9:0]);
        write <= 1'b0;
      end

      // A timed-out read still answers, with a recognisable marker word.
      if ((state == BUS_RD) && bus_done)
        tx <= ready ? rdata : DATA_W'(32'hDEAD_BEEF);
      else if ((state == RDATA) && sck_fall && loaded)
        tx <= {tx[DATA_W-2:0], 1'b0};

      if (state != RDATA) loaded <= 1'b0;
      else if (sck_fall)  loaded <= 1'b1;

      if (state == IDLE)  abort <= 1'b0;
      else if (csn_rise)  abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed testbench for spi_reg_bridge: drives SPI mode-0 frames and a simple bus responder,
// comparing bus captures and MISO words against hand-computed values.
module tb_spi_reg_bridge;

  localparam int HALF = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        ready = 1'b0;
  logic        spi_miso, spi_miso_oe, val, write, busy, frame_err, timeout_err;
  logic [9:0]  addr;
  logic [31:0] wdata;

  int checks = 0;
  int passed = 0;

  int val_pulses = 0, val_cycles = 0, fe_pulses = 0, fe_cycles = 0, stab_err = 0;
  logic [9:0]  cap_addr = '0;
  logic        cap_write = 1'b0;
  logic [31:0] cap_wdata = '0;
  logic        val_prev = 1'b0, fe_prev = 1'b0;
  bit          ready_en = 1'b1;
  int          rcnt = 0;
  bit          oe_seen = 1'b0;
  logic [55:0] mi;

  spi_reg_bridge #(
    .ADDR_W(10), .DATA_W(32), .SYNC_STAGES(2), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rstn(rstn),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .val(val), .addr(addr), .write(write), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Bus monitor and ready responder: ready rises on the second clk of val.
  initial forever begin
    @(negedge clk);
    if (val === 1'b1) begin
      val_cycles++;
      if (!val_prev) begin
        val_pulses++;
        cap_addr  = addr;
        cap_write = write;
        cap_wdata = wdata;
      end else if (addr !== cap_addr || write !== cap_write || wdata !== cap_wdata) begin
        stab_err++;
      end
    end
    if (frame_err === 1'b1) begin
      fe_cycles++;
      if (!fe_prev) fe_pulses++;
    end
    val_prev = (val === 1'b1);
    fe_prev  = (frame_err === 1'b1);
    if (val === 1'b1 && ready_en) begin
      rcnt++;
      ready = (rcnt >= 2);
    end else begin
      rcnt  = 0;
      ready = 1'b0;
    end
  end

  task automatic spi_frame(input logic [55:0] mo, input int nbits, input bit end_cs,
                           output logic [55:0] mi_out);
    mi_out  = '0;
    spi_csn = 1'b0;
    #(2*HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[55-i];
      #HALF;
      spi_sck = 1'b1;
      mi_out[55-i] = spi_miso;
      if (i == 0) oe_seen = spi_miso_oe;
      #HALF;
      spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
    if (end_cs) begin
      #(2*HALF);
      spi_csn = 1'b1;
      #(4*HALF);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #22;
    checks++;
    if ({val, write, addr, wdata, spi_miso, spi_miso_oe, busy, frame_err, timeout_err} !== '0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {val, write, addr, wdata, spi_miso, spi_miso_oe, busy, frame_err, timeout_err});
    else passed++;
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({val, busy, spi_miso, spi_miso_oe, frame_err, timeout_err} !== 6'b0)
      $display("[TB] FAIL idle_after_reset: got %b expected 000000",
               {val, busy, spi_miso, spi_miso_oe, frame_err, timeout_err});
    else passed++;
  endtask

  task automatic test_write();
    int v0, c0, f0;
    v0 = val_pulses; c0 = val_cycles; f0 = fe_pulses;
    ready_en = 1'b1;
    spi_frame({16'h8200, 32'h0012_3456, 8'h00}, 48, 1'b1, mi);
    checks++;
    if (val_pulses - v0 !== 1) $display("[TB] FAIL wr_val_pulses: got %0d expected 1", val_pulses - v0);
    else passed++;
    checks++;
    if (cap_write !== 1'b1) $display("[TB] FAIL wr_write: got %b expected 1", cap_write);
    else passed++;
    checks++;
    if (cap_addr !== 10'h200) $display("[TB] FAIL wr_addr: got %h expected 200", cap_addr);
    else passed++;
    checks++;
    if (cap_wdata !== 32'h0012_3456) $display("[TB] FAIL wr_wdata: got %h expected 00123456", cap_wdata);
    else passed++;
    checks++;
    if (val_cycles - c0 !== 2) $display("[TB] FAIL wr_val_len: got %0d expected 2", val_cycles - c0);
    else passed++;
    checks++;
    if (fe_pulses - f0 !== 0) $display("[TB] FAIL wr_frame_err: got %0d expected 0", fe_pulses - f0);
    else passed++;
    checks++;
    if ({oe_seen, busy, spi_miso_oe} !== 3'b100)
      $display("[TB] FAIL wr_oe_busy: got %b expected 100", {oe_seen, busy, spi_miso_oe});
    else passed++;
  endtask

  task automatic test_read();
    int v0, f0;
    v0 = val_pulses; f0 = fe_pulses;
    rdata = 32'h0000_0001;
    spi_frame({16'h0300, 40'h0}, 56, 1'b1, mi);
    checks++;
    if (mi[31:0] !== 32'h0000_0001) $display("[TB] FAIL rd_miso_data: got %h expected 00000001", mi[31:0]);
    else passed++;
    checks++;
    if (mi[55:32] !== 24'h0) $display("[TB] FAIL rd_miso_turn: got %h expected 000000", mi[55:32]);
    else passed++;
    checks++;
    if (val_pulses - v0 !== 1) $display("[TB] FAIL rd_val_pulses: got %0d expected 1", val_pulses - v0);
    else passed++;
    checks++;
    if ({cap_write, cap_addr} !== {1'b0, 10'h300})
      $display("[TB] FAIL rd_bus_cmd: got %b/%h expected 0/300", cap_write, cap_addr);
    else passed++;
    checks++;
    if ({timeout_err, 1'(fe_pulses != f0)} !== 2'b00)
      $display("[TB] FAIL rd_errors: got %b expected 00", {timeout_err, 1'(fe_pulses != f0)});
    else passed++;
  endtask

  task automatic test_timeout();
    int v0, c0, f0;
    v0 = val_pulses; c0 = val_cycles; f0 = fe_pulses;
    ready_en = 1'b0;
    rdata = 32'h1234_5678;
    spi_frame({16'h03FF, 40'h0}, 56, 1'b1, mi);
    ready_en = 1'b1;
    checks++;
    if (val_cycles - c0 !== 15) $display("[TB] FAIL to_val_len: got %0d expected 15", val_cycles - c0);
    else passed++;
    checks++;
    if (val_pulses - v0 !== 1) $display("[TB] FAIL to_val_pulses: got %0d expected 1", val_pulses - v0);
    else passed++;
    checks++;
    if (timeout_err !== 1'b1) $display("[TB] FAIL to_sticky: got %b expected 1", timeout_err);
    else passed++;
    checks++;
    if (mi[31:0] !== 32'hDEAD_BEEF) $display("[TB] FAIL to_miso: got %h expected deadbeef", mi[31:0]);
    else passed++;
    checks++;
    if (cap_addr !== 10'h3FF) $display("[TB] FAIL to_addr: got %h expected 3ff", cap_addr);
    else passed++;
    checks++;
    if (fe_pulses - f0 !== 0) $display("[TB] FAIL to_frame_err: got %0d expected 0", fe_pulses - f0);
    else passed++;
  endtask

  task automatic test_short_frame();
    int v0, f0, fc0;
    v0 = val_pulses; f0 = fe_pulses; fc0 = fe_cycles;
    spi_frame({16'h8200, 32'hFFFF_FFFF, 8'h00}, 20, 1'b1, mi);
    checks++;
    if (val_pulses - v0 !== 0) $display("[TB] FAIL short_val: got %0d expected 0", val_pulses - v0);
    else passed++;
    checks++;
    if (fe_pulses - f0 !== 1) $display("[TB] FAIL short_fe_pulses: got %0d expected 1", fe_pulses - f0);
    else passed++;
    checks++;
    if (fe_cycles - fc0 !== 1) $display("[TB] FAIL short_fe_width: got %0d expected 1", fe_cycles - fc0);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL short_busy: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reserved();
    int v0, f0, fc0;
    v0 = val_pulses; f0 = fe_pulses; fc0 = fe_cycles;
    spi_frame({16'h8500, 32'hCAFE_F00D, 8'h00}, 48, 1'b1, mi);
    checks++;
    if (val_pulses - v0 !== 0) $display("[TB] FAIL rsv_val: got %0d expected 0", val_pulses - v0);
    else passed++;
    checks++;
    if ({fe_pulses - f0, fe_cycles - fc0} !== {32'd1, 32'd1})
      $display("[TB] FAIL rsv_fe: got %0d pulses %0d cycles expected 1 1", fe_pulses - f0, fe_cycles - fc0);
    else passed++;
    v0 = val_pulses; f0 = fe_pulses;
    spi_frame({16'h8055, 32'hA5A5_5A5A, 8'h00}, 48, 1'b1, mi);
    checks++;
    if (val_pulses - v0 !== 1) $display("[TB] FAIL rsv_next_val: got %0d expected 1", val_pulses - v0);
    else passed++;
    checks++;
    if ({cap_write, cap_addr, cap_wdata} !== {1'b1, 10'h055, 32'hA5A5_5A5A})
      $display("[TB] FAIL rsv_next_bus: got %b/%h/%h expected 1/055/a5a55a5a", cap_write, cap_addr, cap_wdata);
    else passed++;
    checks++;
    if (fe_pulses - f0 !== 0) $display("[TB] FAIL rsv_next_fe: got %0d expected 0", fe_pulses - f0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = val_pulses;
    spi_frame({16'h8001, 32'h1111_2222, 8'h00}, 48, 1'b1, mi);
    checks++;
    if (cap_wdata !== 32'h1111_2222) $display("[TB] FAIL b2b_wdata: got %h expected 11112222", cap_wdata);
    else passed++;
    rdata = 32'h8000_00FF;
    spi_frame({16'h0002, 40'h0}, 56, 1'b1, mi);
    checks++;
    if (val_pulses - v0 !== 2) $display("[TB] FAIL b2b_val_pulses: got %0d expected 2", val_pulses - v0);
    else passed++;
    checks++;
    if (mi[31:0] !== 32'h8000_00FF) $display("[TB] FAIL b2b_miso: got %h expected 800000ff", mi[31:0]);
    else passed++;
    checks++;
    if ({cap_write, cap_addr} !== {1'b0, 10'h002})
      $display("[TB] FAIL b2b_rd_cmd: got %b/%h expected 0/002", cap_write, cap_addr);
    else passed++;
    checks++;
    if (stab_err !== 0) $display("[TB] FAIL bus_stable: got %0d changes expected 0", stab_err);
    else passed++;
  endtask

  task automatic test_reset_in_bus_rd();
    bit seen;
    ready_en = 1'b0;
    spi_frame({16'h0155, 40'h0}, 16, 1'b0, mi);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (val === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) $display("[TB] FAIL rst_bus_wait: got no val expected val within 50 clk");
    else passed++;
    checks++;
    if ({busy, spi_miso_oe} !== 2'b11) $display("[TB] FAIL rst_bus_pre: got %b expected 11", {busy, spi_miso_oe});
    else passed++;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({val, busy, spi_miso_oe, timeout_err} !== 4'b0000)
      $display("[TB] FAIL rst_bus_async: got %b expected 0000", {val, busy, spi_miso_oe, timeout_err});
    else passed++;
    spi_csn = 1'b1;
    #50;
    rstn = 1'b1;
    ready_en = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({val, busy, frame_err} !== 3'b000)
      $display("[TB] FAIL rst_bus_idle: got %b expected 000", {val, busy, frame_err});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_short_frame();
    test_reserved();
    test_back_to_back();
    test_reset_in_bus_rd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
